// File: rtl/madgwick_vp_pkg.sv
// Shared types and helpers for the madgwick vector player: FSM states, sample/quaternion layouts
// and the saturating counter increment.
package madgwick_vp_pkg;

  localparam int VP_ACC_W  = 16;
  localparam int VP_GYRO_W = 16;
  localparam int VP_Q_W    = 16;
  localparam int VP_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_COLLECT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_ADVANCE = 3'd6
  } vp_state_t;

  typedef struct packed {
    logic signed [VP_ACC_W-1:0]  ax;
    logic signed [VP_ACC_W-1:0]  ay;
    logic signed [VP_ACC_W-1:0]  az;
    logic signed [VP_GYRO_W-1:0] wx;
    logic signed [VP_GYRO_W-1:0] wy;
    logic signed [VP_GYRO_W-1:0] wz;
  } imu_sample_t;

  typedef struct packed {
    logic signed [VP_Q_W-1:0] w;
    logic signed [VP_Q_W-1:0] x;
    logic signed [VP_Q_W-1:0] y;
    logic signed [VP_Q_W-1:0] z;
  } quat_t;

  // Counters up to 32 bits wide share this; the caller supplies its own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    if (val >= max_val) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/madgwick_vector_player_cmp.sv
// quat_tol_cmp: combinational check that all four quaternion components lie within TOL LSBs
// of the golden value.
module quat_tol_cmp #(
  parameter int Q_W = 16,
  parameter int TOL = 4
) (
  input  logic [4*Q_W-1:0] dut_q_i,
  input  logic [4*Q_W-1:0] gold_q_i,
  output logic             pass_o
);

  localparam int QX_W = Q_W + 1;
  localparam logic [Q_W:0] TOL_V = QX_W'(TOL);

  logic [Q_W:0] diff_s [4];
  logic [Q_W:0] mag_s  [4];

  // One extra bit keeps both the difference and its magnitude free of overflow at full scale
  always_comb begin
    pass_o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      diff_s[i] = {dut_q_i[i*Q_W+Q_W-1], dut_q_i[i*Q_W +: Q_W]}
                - {gold_q_i[i*Q_W+Q_W-1], gold_q_i[i*Q_W +: Q_W]};
      if (diff_s[i][Q_W]) begin
        mag_s[i] = -diff_s[i];
      end else begin
        mag_s[i] = diff_s[i];
      end
      if (mag_s[i] > TOL_V) begin
        pass_o = 1'b0;
      end else begin
        pass_o = pass_o;
      end
    end
  end

endmodule

// File: rtl/madgwick_vector_player.sv
// madgwick_vector_player: replays stored IMU vectors through the filter and scores its quaternions.
// Optional per-phase handshake watchdog and timeout_cnt port: define VECPLAYER_TIMEOUT_EN.
module madgwick_vector_player
  import madgwick_vp_pkg::*;
#(
  parameter int ACC_W   = VP_ACC_W,
  parameter int GYRO_W  = VP_GYRO_W,
  parameter int Q_W     = VP_Q_W,
  parameter int NUM_VEC = 256,
  parameter int ADDR_W  = $clog2(NUM_VEC),
  parameter int TOL     = 4,
  parameter int CNT_W   = VP_CNT_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          loop_mode,
  input  logic                          stop,
  input  logic                          abort,
  output logic                          vec_rd_en,
  output logic [ADDR_W-1:0]             vec_addr,
  input  logic [3*ACC_W+3*GYRO_W-1:0]   vec_imu,
  input  logic [4*Q_W-1:0]              vec_gold,
  output logic                          dut_valid_in,
  input  logic                          dut_ready_in,
  output logic [3*ACC_W+3*GYRO_W-1:0]   dut_imu,
  input  logic                          dut_valid_out,
  output logic                          dut_ready_out,
  input  logic [4*Q_W-1:0]              dut_q,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              pass_cnt,
  output logic [CNT_W-1:0]              fail_cnt,
  output logic [CNT_W-1:0]              loop_cnt,
`ifdef VECPLAYER_TIMEOUT_EN
  output logic [CNT_W-1:0]              timeout_cnt,
`endif
  output logic [ADDR_W:0]               first_fail
);

  localparam int IMU_W = 3*ACC_W + 3*GYRO_W;
  localparam int QV_W  = 4*Q_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

  vp_state_t          state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               loop_q;
  logic               rd_en_q;
  logic               valid_in_q;
  logic               ready_out_q;
  logic               busy_q;
  logic               done_q;
  logic [IMU_W-1:0]   imu_q;
  logic [QV_W-1:0]    gold_q;
  logic [QV_W-1:0]    res_q;
  logic [CNT_W-1:0]   pass_q;
  logic [CNT_W-1:0]   fail_q;
  logic [CNT_W-1:0]   loop_cnt_q;
  logic [ADDR_W:0]    first_fail_q;

  logic [CNT_W-1:0]   pass_d;
  logic [CNT_W-1:0]   fail_d;
  logic [CNT_W-1:0]   loop_cnt_d;
  logic [ADDR_W:0]    first_fail_d;
  logic               cmp_pass_s;
  logic               start_acc_s;
  logic               tmo_hit_s;

  assign pass_d       = CNT_W'(sat_inc(32'(pass_q), CNT_MAX));
  assign fail_d       = CNT_W'(sat_inc(32'(fail_q), CNT_MAX));
  assign loop_cnt_d   = CNT_W'(sat_inc(32'(loop_cnt_q), CNT_MAX));
  assign first_fail_d = first_fail_q[ADDR_W] ? first_fail_q : {1'b1, addr_q};
  assign start_acc_s  = (state_q == ST_IDLE) && start && !abort;

  quat_tol_cmp #(
    .Q_W (Q_W),
    .TOL (TOL)
  ) u_cmp (
    .dut_q_i  (res_q),
    .gold_q_i (gold_q),
    .pass_o   (cmp_pass_s)
  );

`ifdef VECPLAYER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] timeout_cnt_q;
  logic             phase_wait_s;

  assign phase_wait_s = ((state_q == ST_DRIVE) && !dut_ready_in)
                     || ((state_q == ST_COLLECT) && !dut_valid_out);
  assign tmo_hit_s    = phase_wait_s && (tmo_q == TMO_LAST);
  assign timeout_cnt  = timeout_cnt_q;

  // Watchdog: counts stalled cycles within one handshake phase and tallies expiries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q         <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (phase_wait_s && !tmo_hit_s && !abort) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end
      if (start_acc_s) begin
        timeout_cnt_q <= '0;
      end else if (tmo_hit_s && !abort) begin
        timeout_cnt_q <= CNT_W'(sat_inc(32'(timeout_cnt_q), CNT_MAX));
      end else begin
        timeout_cnt_q <= timeout_cnt_q;
      end
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
  assign tmo_hit_s = 1'b0;
`endif

  // Run sequencer: walks the vector memory, drives both filter handshakes and scores each result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      loop_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      valid_in_q   <= 1'b0;
      ready_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      imu_q        <= '0;
      gold_q       <= '0;
      res_q        <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      loop_cnt_q   <= '0;
      first_fail_q <= '0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      valid_in_q  <= 1'b0;
      ready_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pass_q       <= '0;
            fail_q       <= '0;
            loop_cnt_q   <= '0;
            first_fail_q <= '0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            loop_q       <= loop_mode;
            rd_en_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          imu_q      <= vec_imu;
          gold_q     <= vec_gold;
          valid_in_q <= 1'b1;
          state_q    <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (dut_ready_in) begin
            valid_in_q  <= 1'b0;
            ready_out_q <= 1'b1;
            state_q     <= ST_COLLECT;
          end else if (tmo_hit_s) begin
            valid_in_q   <= 1'b0;
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
            state_q      <= ST_ADVANCE;
          end
        end
        ST_COLLECT: begin
          if (dut_valid_out) begin
            res_q       <= dut_q;
            ready_out_q <= 1'b0;
            state_q     <= ST_CHECK;
          end else if (tmo_hit_s) begin
            ready_out_q  <= 1'b0;
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
            state_q      <= ST_ADVANCE;
          end
        end
        ST_CHECK: begin
          if (cmp_pass_s) begin
            pass_q <= pass_d;
          end else begin
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
          end
          state_q <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (addr_q != LAST_ADDR) begin
            addr_q  <= addr_q + ADDR_W'(1);
            rd_en_q <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            loop_cnt_q <= loop_cnt_d;
            // stop is only looked at here, so a pulse that ends mid-pass is harmless
            if (loop_q && !stop) begin
              addr_q  <= '0;
              rd_en_q <= 1'b1;
              state_q <= ST_FETCH;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rd_en_q     <= 1'b0;
          valid_in_q  <= 1'b0;
          ready_out_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign vec_rd_en     = rd_en_q;
  assign vec_addr      = addr_q;
  assign dut_valid_in  = valid_in_q;
  assign dut_imu       = imu_q;
  assign dut_ready_out = ready_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass_cnt      = pass_q;
  assign fail_cnt      = fail_q;
  assign loop_cnt      = loop_cnt_q;
  assign first_fail    = first_fail_q;

endmodule

// File: tb/tb_madgwick_vector_player.sv
// Scoreboard bench for madgwick_vector_player with a vector memory and a behavioural filter model.
// The timeout scenario is built only when VECPLAYER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_madgwick_vector_player;

  localparam int NV = 4;
  localparam int AW = 2;
  localparam int IW = 96;
  localparam int QW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          loop_mode = 1'b0;
  logic          stop = 1'b0;
  logic          abort = 1'b0;
  logic          vec_rd_en;
  logic [AW-1:0] vec_addr;
  logic [IW-1:0] vec_imu;
  logic [QW-1:0] vec_gold;
  logic          dut_valid_in;
  logic          dut_ready_in;
  logic [IW-1:0] dut_imu;
  logic          dut_valid_out;
  logic          dut_ready_out;
  logic [QW-1:0] dut_q;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] loop_cnt;
  logic [AW:0]   first_fail;
`ifdef VECPLAYER_TIMEOUT_EN
  logic [CW-1:0] timeout_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  madgwick_vector_player #(
    .ACC_W(16), .GYRO_W(16), .Q_W(16), .NUM_VEC(NV), .TOL(4), .CNT_W(CW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_mode(loop_mode), .stop(stop), .abort(abort),
    .vec_rd_en(vec_rd_en), .vec_addr(vec_addr), .vec_imu(vec_imu), .vec_gold(vec_gold),
    .dut_valid_in(dut_valid_in), .dut_ready_in(dut_ready_in), .dut_imu(dut_imu),
    .dut_valid_out(dut_valid_out), .dut_ready_out(dut_ready_out), .dut_q(dut_q),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .loop_cnt(loop_cnt),
`ifdef VECPLAYER_TIMEOUT_EN
    .timeout_cnt(timeout_cnt),
`endif
    .first_fail(first_fail)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Vector memory: registered read, one cycle after the strobe
  logic [IW-1:0] mem_imu  [NV];
  logic [QW-1:0] mem_gold [NV];
  logic [QW-1:0] resp     [NV];

  always @(posedge clk) begin
    if (vec_rd_en) begin
      vec_imu  <= mem_imu[vec_addr];
      vec_gold <= mem_gold[vec_addr];
    end
  end

  // Filter model: answers with resp[ax index] after lat_cycles; never_idx swallows that sample
  int   hold_cycles = 0;
  int   lat_cycles = 2;
  int   never_idx = -1;
  int   fm_hold;
  int   fm_lat;
  int   fm_idx;
  logic fm_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_ready_in  <= 1'b0;
      dut_valid_out <= 1'b0;
      dut_q         <= '0;
      fm_busy       <= 1'b0;
      fm_hold       <= 0;
      fm_lat        <= 0;
      fm_idx        <= 0;
    end else if (!fm_busy) begin
      if (dut_valid_in && dut_ready_in) begin
        dut_ready_in <= 1'b0;
        fm_busy      <= 1'b1;
        fm_lat       <= lat_cycles;
        fm_idx       <= int'(dut_imu[81:80]);
        fm_hold      <= 0;
      end else if (dut_valid_in) begin
        if (fm_hold >= hold_cycles) dut_ready_in <= 1'b1;
        else fm_hold <= fm_hold + 1;
      end else begin
        dut_ready_in <= 1'b0;
      end
    end else if (dut_valid_out) begin
      if (dut_ready_out) begin
        dut_valid_out <= 1'b0;
        fm_busy       <= 1'b0;
      end
    end else if (fm_lat > 0) begin
      fm_lat <= fm_lat - 1;
    end else if (fm_idx == never_idx) begin
      fm_busy <= 1'b0;
    end else begin
      dut_valid_out <= 1'b1;
      dut_q         <= resp[fm_idx];
    end
  end

  // Scoreboard queues filled by stimulus, drained by the monitors
  typedef struct packed {
    logic [15:0] p;
    logic [15:0] f;
    logic [15:0] l;
    logic [2:0]  ff;
  } res_t;

  logic [IW-1:0] exp_imu [$];
  res_t          exp_res [$];

  logic [IW-1:0] prev_imu;
  logic          prev_wait = 1'b0;
  logic          done_prev = 1'b0;

  // Input-side monitor: handshake payload order plus valid/data stability while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("valid_in_held", dut_valid_in, 1'b1);
        chk("imu_held", dut_imu, prev_imu);
      end
      if (dut_valid_in && dut_ready_in) begin
        if (exp_imu.size() == 0) chk("imu_unexpected", 1'b1, 1'b0);
        else chk("imu_payload", dut_imu, exp_imu.pop_front());
      end
      prev_wait = dut_valid_in && !dut_ready_in;
      prev_imu  = dut_imu;
    end
  end

  // Result monitor: compares statistics whenever a run completes
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (exp_res.size() == 0) begin
          chk("done_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_res.pop_front();
          chk("pass_cnt", pass_cnt, e.p);
          chk("fail_cnt", fail_cnt, e.f);
          chk("loop_cnt", loop_cnt, e.l);
          chk("first_fail", first_fail, e.ff);
        end
      end
      done_prev = done;
    end
  end

  task automatic init_tables();
    for (int i = 0; i < NV; i++) begin
      mem_imu[i] = {16'(i), 16'(16'h0100 + i), 16'(16'h0200 + i),
                    16'(16'h0300 + i), 16'(16'h0400 + i), 16'(16'h0500 + i)};
    end
    mem_gold[0] = {16'h4000, 16'h1111, 16'h2222, 16'h3333};
    mem_gold[1] = {16'h7000, 16'hF000, 16'h0123, 16'h8001};
    mem_gold[2] = {16'hC000, 16'h0400, 16'hFFFC, 16'h0010};
    mem_gold[3] = {16'h0001, 16'h1000, 16'h7FF0, 16'hA000};
    for (int i = 0; i < NV; i++) resp[i] = mem_gold[i];
    hold_cycles = 0;
    lat_cycles  = 2;
    never_idx   = -1;
  endtask

  task automatic push_vecs(input int passes, input int count);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < count; i++) exp_imu.push_back(mem_imu[i]);
  endtask

  task automatic push_res(input int p, input int f, input int l, input logic [2:0] ff);
    res_t r;
    r.p = 16'(p); r.f = 16'(f); r.l = 16'(l); r.ff = ff;
    exp_res.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; loop_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run(input logic lm);
    loop_mode = lm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    init_tables();
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass_cnt, 16'd0);
    chk("rst_fail", fail_cnt, 16'd0);
    chk("rst_loop", loop_cnt, 16'd0);
    chk("rst_first_fail", first_fail, 3'd0);
    chk("rst_valid_in", dut_valid_in, 1'b0);
    chk("rst_ready_out", dut_ready_out, 1'b0);
    chk("rst_rd_en", vec_rd_en, 1'b0);
    chk("rst_imu", dut_imu, 96'd0);

    // Exact echo, single pass; a start while busy must not restart the run
    init_tables();
    push_vecs(1, NV);
    push_res(4, 0, 1, 3'b000);
    start_run(1'b0);
    chk("busy_after_start", busy, 1'b1);
    repeat (5) @(negedge clk);
    start_run(1'b0);
    wait_done("t1_done", 400);

    // Vector 2 qx off by 5 fails, vector 3 qx off by 4 passes
    init_tables();
    resp[2][47:32] = 16'h0405;
    resp[3][47:32] = 16'h0FFC;
    push_vecs(1, NV);
    push_res(3, 1, 1, 3'b110);
    start_run(1'b0);
    wait_done("t2_done", 400);

    // Full-scale qw difference must fail, -32764 vs -32768 must pass
    init_tables();
    mem_gold[0][63:48] = 16'h8000;
    resp[0]            = mem_gold[0];
    resp[0][63:48]     = 16'h7FFF;
    mem_gold[1][63:48] = 16'h8000;
    resp[1]            = mem_gold[1];
    resp[1][63:48]     = 16'h8004;
    push_vecs(1, NV);
    push_res(3, 1, 1, 3'b100);
    start_run(1'b0);
    wait_done("t3_done", 400);

    // Loop mode: early stop pulse ignored, stop during pass 3 ends after pass 3
    init_tables();
    push_vecs(3, NV);
    push_res(12, 0, 3, 3'b000);
    start_run(1'b1);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    n = 0;
    while (loop_cnt != 16'd2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_pass3", loop_cnt, 16'd2);
    chk("t4_busy_pass3", busy, 1'b1);
    stop = 1'b1;
    wait_done("t4_done", 400);
    stop = 1'b0;

    // ready_in stall then abort while collecting vector 1
    init_tables();
    hold_cycles = 10;
    lat_cycles  = 6;
    push_vecs(1, 2);
    start_run(1'b0);
    n = 0;
    while (!(dut_ready_out && pass_cnt == 16'd1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_collect", dut_ready_out && (pass_cnt == 16'd1), 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready_out", dut_ready_out, 1'b0);
    chk("abort_valid_in", dut_valid_in, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_pass_kept", pass_cnt, 16'd1);
    chk("abort_fail_kept", fail_cnt, 16'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 1'b0);
    do_reset();

`ifdef VECPLAYER_TIMEOUT_EN
    // Filter swallows vector 0: watchdog fails it and the run carries on
    init_tables();
    never_idx = 0;
    push_vecs(1, NV);
    push_res(3, 1, 1, 3'b100);
    start_run(1'b0);
    wait_done("t6_done", 600);
    chk("t6_timeout_cnt", timeout_cnt, 16'd1);
    do_reset();
`endif

    // Asynchronous reset in the middle of a run
    init_tables();
    push_vecs(1, NV);
    start_run(1'b0);
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_valid_in", dut_valid_in, 1'b0);
    chk("async_rst_ready_out", dut_ready_out, 1'b0);
    chk("async_rst_pass", pass_cnt, 16'd0);
    exp_imu.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("imu_queue_drained", 128'(exp_imu.size()), 128'd0);
    chk("res_queue_drained", 128'(exp_res.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
